// File: rtl/shiftin_pkg.sv
// Shared types and constants for the serial-to-parallel stream receiver.
package shiftin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shiftin_outbuf.sv
// Output word register with valid/ready handshake and a one-cycle load strobe.
module shiftin_outbuf #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] load_data,
    input  logic                 ready,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] data,
    output logic                 fx
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            fx    <= 1'b0;
        end else begin
            fx <= load;
            // A load on the same edge as a handshake keeps valid high with new data.
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shiftin_stream.sv
// Serial bit stream to parallel word assembler with a single-entry output register.
module shiftin_stream
    import shiftin_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 X_in,
    input  logic                 Sx,
    input  logic                 abort,
    input  logic                 msb_first,
    input  logic                 sign_ext,
    output logic [OUT_WIDTH-1:0] X_parallel,
    output logic                 X_valid,
    input  logic                 X_ready,
    output logic                 Fx,
    output logic                 busy,
    output logic                 overrun
);

    localparam int COUNTER_WIDTH = clog2(DATA_WIDTH) + 1;

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]    sreg;
    logic                     msb_l;
    logic                     sext_l;

    logic                     free;
    logic                     msb;
    logic [DATA_WIDTH-1:0]    base;
    logic [DATA_WIDTH-1:0]    shifted;
    logic [DATA_WIDTH-1:0]    word;
    logic                     last;
    logic                     load;
    logic [OUT_WIDTH-1:0]     load_data;

    assign free = !X_valid || X_ready;
    assign busy = (state != IDLE);

    always_comb begin
        // A new word always starts from an empty shift register.
        msb     = (state == IDLE) ? msb_first : msb_l;
        base    = (state == IDLE) ? '0 : sreg;
        shifted = msb ? {base[DATA_WIDTH-2:0], X_in} : {X_in, base[DATA_WIDTH-1:1]};
        last    = (state == SHIFT) && Sx && !abort
                  && (cnt == COUNTER_WIDTH'(DATA_WIDTH - 1));
        word    = (state == HOLD) ? sreg : shifted;
        load    = free && (last || (state == HOLD));
        load_data = '0;
        load_data[DATA_WIDTH-1:0] = word;
        for (int i = DATA_WIDTH; i < OUT_WIDTH; i++) begin
            load_data[i] = sext_l & word[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            msb_l   <= 1'b0;
            sext_l  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Sx) begin
                        sreg   <= shifted;
                        cnt    <= COUNTER_WIDTH'(1);
                        msb_l  <= msb_first;
                        sext_l <= sign_ext;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        cnt   <= '0;
                        sreg  <= '0;
                        state <= IDLE;
                    end else if (Sx) begin
                        if (last && free) begin
                            cnt   <= '0;
                            sreg  <= '0;
                            state <= IDLE;
                        end else begin
                            sreg  <= shifted;
                            cnt   <= cnt + COUNTER_WIDTH'(1);
                            state <= last ? HOLD : SHIFT;
                        end
                    end
                end
                HOLD: begin
                    if (Sx) overrun <= 1'b1;
                    if (free) begin
                        cnt   <= '0;
                        sreg  <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    sreg  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    shiftin_outbuf #(
        .OUT_WIDTH(OUT_WIDTH)
    ) u_outbuf (
        .clk      (Clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_data(load_data),
        .ready    (X_ready),
        .valid    (X_valid),
        .data     (X_parallel),
        .fx       (Fx)
    );

endmodule

// File: tb/tb_shiftin_stream.sv
// Randomized and directed bench for shiftin_stream against a transaction-level model.
module tb_shiftin_stream;

    localparam int DW = 8;
    localparam int OW = 16;

    logic          Clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          X_in = 1'b0;
    logic          Sx = 1'b0;
    logic          abort = 1'b0;
    logic          msb_first = 1'b0;
    logic          sign_ext = 1'b0;
    logic          X_ready = 1'b0;
    logic [OW-1:0] X_parallel;
    logic          X_valid;
    logic          Fx;
    logic          busy;
    logic          overrun;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: bits of the word in progress, a parked word, and the output register.
    int      bit_q[$];
    bit      m_msb, m_sext;
    bit      held;
    longint  held_word;
    bit      m_valid, m_fx, m_ovr;
    longint  m_data;

    shiftin_stream #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .Clk(Clk), .reset_n(reset_n), .X_in(X_in), .Sx(Sx), .abort(abort),
        .msb_first(msb_first), .sign_ext(sign_ext), .X_parallel(X_parallel),
        .X_valid(X_valid), .X_ready(X_ready), .Fx(Fx), .busy(busy), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint assemble();
        longint v = 0;
        for (int i = 0; i < DW; i++) begin
            if (bit_q[i] != 0) v |= m_msb ? (64'd1 << (DW - 1 - i)) : (64'd1 << i);
        end
        if (m_sext && v[DW-1]) v |= ((64'd1 << OW) - 1) & ~((64'd1 << DW) - 1);
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit x, input bit sx, input bit ab,
                              input bit msbf, input bit sext, input bit rdy);
        bit     free, ld;
        longint nw;
        if (!rst) begin
            bit_q.delete(); held = 0; held_word = 0;
            m_valid = 0; m_fx = 0; m_ovr = 0; m_data = 0;
            return;
        end
        free = !m_valid || rdy;
        ld = 0; nw = 0;
        if (held) begin
            if (sx) m_ovr = 1;
            if (free) begin ld = 1; nw = held_word; held = 0; end
        end else if (bit_q.size() > 0) begin
            if (ab) bit_q.delete();
            else if (sx) begin
                bit_q.push_back(int'(x));
                if (bit_q.size() == DW) begin
                    nw = assemble();
                    bit_q.delete();
                    if (free) ld = 1;
                    else begin held = 1; held_word = nw; end
                end
            end
        end else if (sx) begin
            m_msb = msbf; m_sext = sext;
            bit_q.push_back(int'(x));
        end
        m_fx = ld;
        if (ld) begin m_valid = 1; m_data = nw; end
        else if (rdy) m_valid = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic cyc(input bit rst, input bit x, input bit sx, input bit ab,
                       input bit msbf, input bit sext, input bit rdy);
        reset_n = rst; X_in = x; Sx = sx; abort = ab;
        msb_first = msbf; sign_ext = sext; X_ready = rdy;
        model_step(rst, x, sx, ab, msbf, sext, rdy);
        @(posedge Clk);
        #1;
        chk("par", 32'(X_parallel), 32'(m_data[OW-1:0]));
        chk("valid", 32'(X_valid), 32'(m_valid));
        chk("fx", 32'(Fx), 32'(m_fx));
        chk("busy", 32'(busy), 32'(held || bit_q.size() > 0));
        chk("ovr", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic send_word(input logic [7:0] val, input bit msbf, input bit sext, input bit rdy);
        for (int i = 0; i < DW; i++) cyc(1, msbf ? val[DW-1-i] : val[i], 1, 0, msbf, sext, rdy);
    endtask

    initial begin
        #2;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 1, 1);
        chk("rst_par", 32'(X_parallel), 32'h0);
        chk("rst_valid", 32'(X_valid), 32'h0);

        // MSB-first sign-extended word 1,0,1,1,0,0,0,1
        send_word(8'hB1, 1, 1, 1);
        chk("msb_sext_par", 32'(X_parallel), 32'hFFB1);
        chk("msb_sext_fx", 32'(Fx), 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("fx_pulse", 32'(Fx), 32'h0);

        // Same bit order received LSB first, zero-extended
        send_word(8'h8D, 0, 0, 1);
        chk("lsb_zext_par", 32'(X_parallel), 32'h008D);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Backpressure: second word parks, Sx while parked sets overrun
        send_word(8'h12, 1, 0, 0);
        send_word(8'h34, 1, 0, 0);
        chk("hold_busy", 32'(busy), 32'h1);
        chk("hold_par", 32'(X_parallel), 32'h0012);
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        chk("hold_ovr", 32'(overrun), 32'h1);
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("drain_par", 32'(X_parallel), 32'h0034);
        chk("drain_fx", 32'(Fx), 32'h1);
        cyc(1, 0, 0, 0, 1, 0, 1);

        // Abort after 5 bits, then a clean word
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 1, 1, 1);
        cyc(1, 1, 1, 1, 1, 1, 1);
        chk("abort_busy", 32'(busy), 32'h0);
        send_word(8'hA5, 1, 0, 1);
        chk("abort_par", 32'(X_parallel), 32'h00A5);

        // Reset mid-word
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 1, 0, 1);
        cyc(0, 1, 1, 0, 1, 0, 1);
        chk("rst_mid_par", 32'(X_parallel), 32'h0);
        chk("rst_mid_ovr", 32'(overrun), 32'h0);
        send_word(8'h5A, 1, 0, 1);
        chk("after_rst_par", 32'(X_parallel), 32'h005A);

        // Reset while a word is parked
        send_word(8'h11, 1, 0, 0);
        send_word(8'h22, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("rst_hold_busy", 32'(busy), 32'h0);
        chk("rst_hold_valid", 32'(X_valid), 32'h0);
        send_word(8'hC3, 0, 1, 1);
        chk("after_hold_par", 32'(X_parallel), 32'hFFC3);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 299) != 0), 1'($urandom), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 9) < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
